// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types for the CPU step clock controller: FSM state encoding and phase-timer width helper.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    HALTED = 2'd3
  } step_state_e;

  localparam int STEP_HIGH_DEF = 2;
  localparam int RUN_HALF_DEF  = 25_000_000;

  // Bits needed to hold the longer of the two phase lengths.
  function automatic int phase_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int PHASE_W = phase_w(STEP_HIGH_DEF, RUN_HALF_DEF);

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Handshake/status bundle between the button stage, the step controller and the display logic.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             StepPulse;
  logic             RunMode;
  logic             Halt;
  logic             CPUCLK;
  logic             CPUCLK_Rise;
  logic [CNT_W-1:0] StepCount;
  logic             Busy;

  modport master (
    output StepPulse, RunMode, Halt,
    input  CPUCLK, CPUCLK_Rise, StepCount, Busy
  );

  modport slave (
    input  StepPulse, RunMode, Halt,
    output CPUCLK, CPUCLK_Rise, StepCount, Busy
  );
endinterface

// File: rtl/cpu_step_ctrl_phase_timer.sv
// Loadable down-counter timing one CPUCLK phase; done is high in the last cycle of the phase.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q == W'(1));
endmodule

// File: rtl/cpu_step_ctrl.sv
// Generates CPUCLK from step events (fixed-width pulses) or free-runs it; freezes on Halt until Reset.
// Optional STEP_QUEUE_EN: one-deep pending step taken at the end of the current pulse.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int STEP_HIGH = 2,
  parameter int RUN_HALF  = 25_000_000,
  parameter int CNT_W     = 16
) (
  input  logic             BasysCLK,
  input  logic             Reset,
  cpu_step_ctrl_if.slave   bus
);
  localparam int PH_W = phase_w(STEP_HIGH, RUN_HALF);
  localparam logic [PH_W-1:0] STEP_LEN = PH_W'(STEP_HIGH);
  localparam logic [PH_W-1:0] RUN_LEN  = PH_W'(RUN_HALF);

  step_state_e      state_q, state_d;
  logic [PH_W-1:0]  len_q, len_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_load, tmr_done, phase_end, step_queued;
  logic [PH_W-1:0]  tmr_val;

  phase_timer #(.W(PH_W)) u_timer (
    .clk_i      (BasysCLK),
    .rst_i      (Reset),
    .load_i     (tmr_load),
    .load_val_i (len_d),
    .value_o    (tmr_val),
    .done_o     (tmr_done)
  );

  // A drained timer also ends the phase so the FSM can never stall in HIGH/LOW.
  assign phase_end = tmr_done | (tmr_val == '0);

`ifdef STEP_QUEUE_EN
  logic pend_q, pend_d;

  assign step_queued = pend_q | (bus.StepPulse & ~bus.RunMode);

  always_comb begin
    pend_d = pend_q;
    if ((state_q == HIGH || state_q == LOW) && bus.StepPulse && !bus.RunMode)
      pend_d = 1'b1;
    if (bus.RunMode || state_d == HALTED || state_d == IDLE ||
        (state_q == LOW && state_d == HIGH))
      pend_d = 1'b0;
  end

  always_ff @(posedge BasysCLK) begin
    if (Reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end
`else
  assign step_queued = 1'b0;
`endif

  always_ff @(posedge BasysCLK) begin
    if (Reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (bus.Halt) begin
          state_d = HALTED;
        end else if (bus.RunMode) begin
          state_d = HIGH;
          len_d   = RUN_LEN;
        end else if (bus.StepPulse) begin
          state_d = HIGH;
          len_d   = STEP_LEN;
        end
      end
      HIGH: if (phase_end) state_d = LOW;
      LOW: begin
        if (phase_end) begin
          if (bus.Halt) begin
            state_d = HALTED;
          end else if (bus.RunMode) begin
            state_d = HIGH;
            len_d   = RUN_LEN;
          end else if (step_queued) begin
            state_d = HIGH;
            len_d   = STEP_LEN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    // The LOW phase reuses the length latched on entry to HIGH.
    tmr_load = (state_d != state_q) && (state_d == HIGH || state_d == LOW);
  end

  always_comb begin
    clk_d  = (state_d == HIGH);
    rise_d = (state_d == HIGH) && (state_q != HIGH);
    busy_d = (state_d != IDLE);
    cnt_d  = rise_d ? cnt_q + 1'b1 : cnt_q;
  end

  assign bus.CPUCLK      = clk_q;
  assign bus.CPUCLK_Rise = rise_q;
  assign bus.Busy        = busy_q;
  assign bus.StepCount   = cnt_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl (STEP_HIGH=2, RUN_HALF=4, CNT_W=4); honours STEP_QUEUE_EN.
module tb_cpu_step_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cpu_step_ctrl_if #(.CNT_W(4)) bus ();

  cpu_step_ctrl #(
    .STEP_HIGH (2),
    .RUN_HALF  (4),
    .CNT_W     (4)
  ) dut (
    .BasysCLK (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Bit i of each stimulus pattern is driven in cycle i; bit i of each expect
  // pattern is the registered output seen one cycle later.
  task automatic run_seq(input string tag, input int n,
                         input logic [63:0] sp, input logic [63:0] rm,
                         input logic [63:0] hl, input logic [63:0] rs,
                         input logic [63:0] ex_clk, input logic [63:0] ex_rise,
                         input logic [63:0] ex_busy);
    for (int i = 0; i < n; i++) begin
      bus.StepPulse = sp[i];
      bus.RunMode   = rm[i];
      bus.Halt      = hl[i];
      rst           = rs[i];
      @(posedge clk); #1;
      check($sformatf("%s.clk[%0d]", tag, i),  32'(bus.CPUCLK),      32'(ex_clk[i]));
      check($sformatf("%s.rise[%0d]", tag, i), 32'(bus.CPUCLK_Rise), 32'(ex_rise[i]));
      check($sformatf("%s.busy[%0d]", tag, i), 32'(bus.Busy),        32'(ex_busy[i]));
    end
    bus.StepPulse = 1'b0;
    bus.RunMode   = 1'b0;
    bus.Halt      = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.StepPulse = 1'b0;
    bus.RunMode   = 1'b0;
    bus.Halt      = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, ".rst_clk"},  32'(bus.CPUCLK),      32'd0);
    check({tag, ".rst_rise"}, 32'(bus.CPUCLK_Rise), 32'd0);
    check({tag, ".rst_busy"}, 32'(bus.Busy),        32'd0);
    check({tag, ".rst_cnt"},  32'(bus.StepCount),   32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.StepPulse = 1'b0;
    bus.RunMode   = 1'b0;
    bus.Halt      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1) single step pulse: 2 high, 2 low
    do_reset("t1");
    run_seq("t1", 6, rng(0, 0), '0, '0, '0, rng(0, 1), rng(0, 0), rng(0, 3));
    check("t1.cnt", 32'(bus.StepCount), 32'd1);

    // 2) second press during HIGH
    do_reset("t2");
`ifdef STEP_QUEUE_EN
    run_seq("t2", 10, rng(0, 0) | rng(2, 2), '0, '0, '0,
            rng(0, 1) | rng(4, 5), rng(0, 0) | rng(4, 4), rng(0, 7));
    check("t2.cnt", 32'(bus.StepCount), 32'd2);
`else
    run_seq("t2", 10, rng(0, 0) | rng(2, 2), '0, '0, '0,
            rng(0, 1), rng(0, 0), rng(0, 3));
    check("t2.cnt", 32'(bus.StepCount), 32'd1);
`endif

    // 3) free run for 40 cycles, then RunMode dropped mid-HIGH
    do_reset("t3");
    run_seq("t3run", 42, '0, rng(0, 39), '0, '0,
            rng(0, 3) | rng(8, 11) | rng(16, 19) | rng(24, 27) | rng(32, 35),
            rng(0, 0) | rng(8, 8) | rng(16, 16) | rng(24, 24) | rng(32, 32),
            rng(0, 39));
    check("t3.cnt", 32'(bus.StepCount), 32'd5);
    do_reset("t3b");
    run_seq("t3drop", 10, '0, rng(0, 1), '0, '0, rng(0, 3), rng(0, 0), rng(0, 7));
    check("t3b.cnt", 32'(bus.StepCount), 32'd1);

    // 4) Halt during a step pulse, then inputs ignored, then Reset
    do_reset("t4");
    run_seq("t4halt", 12, rng(0, 0), '0, rng(2, 63), '0, rng(0, 1), rng(0, 0), rng(0, 11));
    run_seq("t4frozen", 10, rng(0, 0) | rng(3, 3), rng(5, 8), '0, '0, '0, '0, rng(0, 9));
    check("t4.cnt_frozen", 32'(bus.StepCount), 32'd1);
    do_reset("t4r");

    // 5) 16 isolated steps: counter wraps to 0
    do_reset("t5");
    for (int k = 0; k < 16; k++) begin
      run_seq($sformatf("t5.%0d", k), 5, rng(0, 0), '0, '0, '0, rng(0, 1), rng(0, 0), rng(0, 3));
      check($sformatf("t5.cnt%0d", k), 32'(bus.StepCount), 32'((k + 1) % 16));
    end

    // 6) Reset in the first HIGH cycle aborts the pulse
    do_reset("t6");
    run_seq("t6", 4, rng(0, 0), '0, '0, rng(1, 1), rng(0, 0), rng(0, 0), rng(0, 0));
    check("t6.cnt", 32'(bus.StepCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
